// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and redirect priority slots.
package fetch_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    // Bit positions in the redirect grant vector; a higher index wins.
    localparam int unsigned RDIR_N   = 3;
    localparam int unsigned RDIR_EXC = 2;
    localparam int unsigned RDIR_IRQ = 1;
    localparam int unsigned RDIR_BR  = 0;

endpackage

// File: rtl/fetch_sequencer_arbiter.sv
// Fixed-priority redirect select (exception > interrupt > branch) with word-aligned target.
module redirect_arbiter
    import fetch_sequencer_pkg::*;
(
    input  logic              exc_req_i,
    input  logic              irq_req_i,
    input  logic              br_req_i,
    input  logic [31:0]       exc_vector_i,
    input  logic [31:0]       irq_vector_i,
    input  logic [31:0]       br_target_i,
    output logic              any_o,
    output logic [RDIR_N-1:0] gnt_o,
    output logic [31:0]       target_o
);

    always_comb begin
        gnt_o    = '0;
        target_o = '0;
        if (exc_req_i) begin
            gnt_o[RDIR_EXC] = 1'b1;
            target_o        = exc_vector_i;
        end else if (irq_req_i) begin
            gnt_o[RDIR_IRQ] = 1'b1;
            target_o        = irq_vector_i;
        end else if (br_req_i) begin
            gnt_o[RDIR_BR] = 1'b1;
            target_o       = br_target_i;
        end
        target_o[1:0] = 2'b00;
    end

    assign any_o = exc_req_i | irq_req_i | br_req_i;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-state instruction fetch sequencer with a one-entry fetch buffer and PC redirect control.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_stall,
    output logic        pc_branch_taken,
    output logic [31:0] pc_branch_target,
    input  logic        exc_req,
    input  logic        irq_req,
    input  logic        br_req,
    input  logic [31:0] exc_vector,
    input  logic [31:0] irq_vector,
    input  logic [31:0] br_target,
    output logic        exc_ack,
    output logic        irq_ack,
    output logic        br_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        pipe_stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic        flush,
    output logic        fetch_err
);

    localparam logic [7:0] CNT_LAST = 8'(WAIT_TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         fv_q, fv_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  finstr_q, finstr_d;
    logic [7:0]   cnt_q, cnt_d;

    logic              rd_any;
    logic [RDIR_N-1:0] rd_gnt;
    logic [31:0]       rd_target;
    logic              consume;

    redirect_arbiter u_arb (
        .exc_req_i    (exc_req),
        .irq_req_i    (irq_req),
        .br_req_i     (br_req),
        .exc_vector_i (exc_vector),
        .irq_vector_i (irq_vector),
        .br_target_i  (br_target),
        .any_o        (rd_any),
        .gnt_o        (rd_gnt),
        .target_o     (rd_target)
    );

    assign consume = fv_q & ~pipe_stall;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        addr_d          = addr_q;
        fv_d            = fv_q;
        fpc_d           = fpc_q;
        finstr_d        = finstr_q;
        cnt_d           = cnt_q;
        pc_stall        = 1'b1;
        pc_branch_taken = 1'b0;
        flush           = 1'b0;
        fetch_err       = 1'b0;
        exc_ack         = 1'b0;
        irq_ack         = 1'b0;
        br_ack          = 1'b0;

        if (consume) fv_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_any) begin
                    pc_branch_taken = 1'b1;
                    pc_stall        = 1'b0;
                    flush           = 1'b1;
                    exc_ack         = rd_gnt[RDIR_EXC];
                    irq_ack         = rd_gnt[RDIR_IRQ];
                    br_ack          = rd_gnt[RDIR_BR];
                    fv_d            = 1'b0;
                end else if (!fv_q || consume) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    // A pending redirect makes this word stale; drop it and keep the PC.
                    if (!rd_any) begin
                        fv_d     = 1'b1;
                        fpc_d    = addr_q;
                        finstr_d = imem_rdata;
                        pc_stall = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err = 1'b1;
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            pc_stall        = 1'b1;
            pc_branch_taken = 1'b0;
            flush           = 1'b0;
            fetch_err       = 1'b0;
            exc_ack         = 1'b0;
            irq_ack         = 1'b0;
            br_ack          = 1'b0;
        end
    end

    assign pc_branch_target = rst ? 32'h0 : rd_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            fv_q     <= 1'b0;
            fpc_q    <= '0;
            finstr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            fv_q     <= fv_d;
            fpc_q    <= fpc_d;
            finstr_q <= finstr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_valid = fv_q;
    assign fetch_pc    = fpc_q;
    assign fetch_instr = finstr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch, stall, redirect priority, discard, timeout, reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_stall, pc_branch_taken;
    logic [31:0] pc_branch_target;
    logic        exc_req, irq_req, br_req;
    logic [31:0] exc_vector, irq_vector, br_target;
    logic        exc_ack, irq_ack, br_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        pipe_stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_instr;
    logic        flush, fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer #(.WAIT_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in),
        .pc_stall(pc_stall), .pc_branch_taken(pc_branch_taken), .pc_branch_target(pc_branch_target),
        .exc_req(exc_req), .irq_req(irq_req), .br_req(br_req),
        .exc_vector(exc_vector), .irq_vector(irq_vector), .br_target(br_target),
        .exc_ack(exc_ack), .irq_ack(irq_ack), .br_ack(br_ack),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pipe_stall(pipe_stall),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .flush(flush), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let inputs settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; pipe_stall = 1'b0;
        exc_req = 1'b1; irq_req = 1'b0; br_req = 1'b0;
        exc_vector = 32'h40; irq_vector = 32'h80; br_target = 32'h100;
        imem_ready = 1'b0; imem_rdata = '0;
        #2;
        chk("rst_pc_stall", 32'(pc_stall), 32'd1);
        chk("rst_taken", 32'(pc_branch_taken), 32'd0);
        chk("rst_target", pc_branch_target, 32'h0);
        chk("rst_exc_ack", 32'(exc_ack), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        cyc(); cyc();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_fpc", fetch_pc, 32'h0);
        chk("rst_finstr", fetch_instr, 32'h0);
        rst = 1'b0; exc_req = 1'b0;

        // Sequential fetch at one instruction per two cycles
        pc_in = 32'h0; #1;
        chk("seq_idle_stall", 32'(pc_stall), 32'd1);
        cyc();
        chk("seq_req0", 32'(imem_req), 32'd1);
        chk("seq_addr0", imem_addr, 32'h0);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD0000; #1;
        chk("seq_adv0", 32'(pc_stall), 32'd0);
        cyc();
        imem_ready = 1'b0; pc_in = 32'h4; #1;
        chk("seq_fv0", 32'(fetch_valid), 32'd1);
        chk("seq_fpc0", fetch_pc, 32'h0);
        chk("seq_finstr0", fetch_instr, 32'hDEAD0000);
        chk("seq_req_drop", 32'(imem_req), 32'd0);
        chk("seq_idle_stall1", 32'(pc_stall), 32'd1);
        cyc();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_consumed", 32'(fetch_valid), 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h11110004; #1;
        chk("seq_adv4", 32'(pc_stall), 32'd0);
        cyc();
        imem_ready = 1'b0; pc_in = 32'h8;

        // Pipe stall holds a full buffer and blocks new requests
        pipe_stall = 1'b1; #1;
        chk("stl_fpc4", fetch_pc, 32'h4);
        chk("stl_pc_stall", 32'(pc_stall), 32'd1);
        cyc(); cyc();
        chk("stl_no_req", 32'(imem_req), 32'd0);
        chk("stl_fv", 32'(fetch_valid), 32'd1);
        chk("stl_fpc", fetch_pc, 32'h4);
        chk("stl_finstr", fetch_instr, 32'h11110004);
        pipe_stall = 1'b0;
        cyc();
        chk("stl_req_same", 32'(imem_req), 32'd1);
        chk("stl_addr8", imem_addr, 32'h8);
        chk("stl_fv_consumed", 32'(fetch_valid), 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h22220008;
        cyc();
        imem_ready = 1'b0; pipe_stall = 1'b1;

        // Simultaneous redirects resolve by priority, one per cycle
        exc_req = 1'b1; irq_req = 1'b1; br_req = 1'b1; #1;
        chk("pri_target_exc", pc_branch_target, 32'h40);
        chk("pri_taken", 32'(pc_branch_taken), 32'd1);
        chk("pri_no_stall", 32'(pc_stall), 32'd0);
        chk("pri_acks_exc", {29'd0, exc_ack, irq_ack, br_ack}, 32'b100);
        chk("pri_flush", 32'(flush), 32'd1);
        cyc();
        exc_req = 1'b0; #1;
        chk("pri_buf_flushed", 32'(fetch_valid), 32'd0);
        chk("pri_target_irq", pc_branch_target, 32'h80);
        chk("pri_acks_irq", {29'd0, exc_ack, irq_ack, br_ack}, 32'b010);
        cyc();
        irq_req = 1'b0; #1;
        chk("pri_target_br", pc_branch_target, 32'h100);
        chk("pri_acks_br", {29'd0, exc_ack, irq_ack, br_ack}, 32'b001);
        cyc();
        br_req = 1'b0; pipe_stall = 1'b0; pc_in = 32'h100;
        cyc();
        chk("wr_addr", imem_addr, 32'h100);

        // Branch request during WAIT: response discarded, redirect applied afterwards
        br_req = 1'b1; br_target = 32'h103; #1;
        chk("wr_no_ack", 32'(br_ack), 32'd0);
        chk("wr_no_taken", 32'(pc_branch_taken), 32'd0);
        cyc();
        chk("wr_addr_stable", imem_addr, 32'h100);
        cyc();
        imem_ready = 1'b1; imem_rdata = 32'h33333333; #1;
        chk("wr_discard_stall", 32'(pc_stall), 32'd1);
        chk("wr_discard_noack", 32'(br_ack), 32'd0);
        cyc();
        imem_ready = 1'b0; #1;
        chk("wr_no_buf", 32'(fetch_valid), 32'd0);
        chk("wr_req_drop", 32'(imem_req), 32'd0);
        chk("wr_taken", 32'(pc_branch_taken), 32'd1);
        chk("wr_target_aligned", pc_branch_target, 32'h100);
        chk("wr_br_ack", 32'(br_ack), 32'd1);
        chk("wr_flush", 32'(flush), 32'd1);
        cyc();
        br_req = 1'b0;
        cyc();

        // Memory never answers: abort on the 16th WAIT cycle and refetch
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_no_err", 32'(fetch_err), 32'd0);
            chk("to_addr", imem_addr, 32'h100);
            cyc();
        end
        #1;
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_pc_held", 32'(pc_stall), 32'd1);
        cyc();
        chk("to_req_drop", 32'(imem_req), 32'd0);
        chk("to_err_pulse", 32'(fetch_err), 32'd0);
        cyc();
        chk("to_reissue_req", 32'(imem_req), 32'd1);
        chk("to_reissue_addr", imem_addr, 32'h100);

        // Reset mid-WAIT, with a late memory response
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h44444444; #1;
        chk("mr_stall", 32'(pc_stall), 32'd1);
        chk("mr_target", pc_branch_target, 32'h0);
        cyc();
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, 32'h0);
        rst = 1'b0; #1;
        chk("mr_late_ignored", 32'(pc_stall), 32'd1);
        imem_ready = 1'b0;
        cyc();
        chk("mr_fv", 32'(fetch_valid), 32'd0);
        chk("mr_fpc", fetch_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Clock and reset SHALL be one clock, clk, with reset rst, synchronous and active-high.
REQ-002 Parameter WAIT_TIMEOUT, 16, maximum cycles spent in WAIT before abort (2..255).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pc_in  in  32  current PC from the program counter.
REQ-006 pc_stall  out  1  holds PC when 1.
REQ-007 pc_branch_taken  out  1  loads pc_branch_target into PC.
REQ-008 pc_branch_target  out  32  redirect address, bits[1:0] forced 0.
REQ-009 exc_req / irq_req / br_req  in  1 each  redirect requests, held high by requester until ack.
REQ-010 exc_vector / irq_vector / br_target  in  32 each  redirect addresses.
REQ-011 exc_ack / irq_ack / br_ack  out  1 each  one-cycle pulse when that redirect is applied.
REQ-012 imem_req  out  1, imem_addr  out  32  instruction memory request, registered.
REQ-013 imem_ready  in  1, imem_rdata  in  32  memory response, valid when imem_ready=1 during WAIT.
REQ-014 pipe_stall  in  1  decode cannot accept.
REQ-015 fetch_valid  out  1, fetch_pc  out  32, fetch_instr  out  32  one-entry fetch buffer.
REQ-016 flush  out  1  pulse when the buffer is discarded by a redirect.
REQ-017 fetch_err  out  1  pulse on timeout abort.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE (no request outstanding) and WAIT (imem_req=1).
REQ-019 Redirect priority SHALL be exc > irq > br; redirect_any = exc_req|irq_req|br_req.
REQ-020 In IDLE with redirect_any=1: pc_branch_taken=1, pc_stall=0, target=highest-priority address with [1:0]=0, matching ack=1, flush=1, fetch_valid cleared at the edge; state stays IDLE.
REQ-021 In IDLE, no redirect, buffer empty or consumed this cycle (fetch_valid & !pipe_stall): at the edge imem_addr<=pc_in, imem_req<=1, state<=WAIT.
REQ-022 A buffer is consumed only when fetch_valid=1 and pipe_stall=0; otherwise fetch_valid, fetch_pc, fetch_instr SHALL hold.
REQ-023 Redirect requests SHALL NOT be applied in WAIT; requesters wait for the ack.
REQ-024 In WAIT, imem_req and imem_addr SHALL remain stable until imem_ready=1 or timeout.
REQ-025 In WAIT with imem_ready=1 and redirect_any=0: buffer<=(1, imem_addr, imem_rdata), pc_stall=0 for that cycle (PC+4), imem_req<=0, state<=IDLE.
REQ-026 In WAIT with imem_ready=1 and redirect_any=1: response discarded, pc_stall=1, imem_req<=0, state<=IDLE.
REQ-027 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without imem_ready; at count WAIT_TIMEOUT-1 without ready: fetch_err=1, imem_req<=0, PC held, state<=IDLE (the same address is refetched).
REQ-028 pc_stall SHALL be 1 in every cycle not covered by REQ-020 or REQ-025; pc_branch_taken SHALL be 0 outside REQ-020.
REQ-029 Throughput SHALL be one instruction per 2 cycles with zero-wait memory (IDLE, WAIT).
REQ-030 pc_in wrap from 0xFFFFFFFC to 0 SHALL need no special handling.

Reset
REQ-031 On rst=1 at an edge: state=IDLE, imem_req=0, imem_addr=0, fetch_valid=0, fetch_pc=0, fetch_instr=0, wait counter=0.
REQ-032 While rst=1: pc_stall=1, pc_branch_taken=0, pc_branch_target=0, all acks, flush and fetch_err=0.
REQ-033 Reset in WAIT SHALL abandon the request; a late imem_ready after reset SHALL be ignored.

Structure
REQ-034 The state encoding and the redirect priority constants SHALL live in the shared CPU package; WAIT_TIMEOUT stays a module parameter.
REQ-035 The priority select plus vector mux SHALL be a sub-module, redirect_arbiter, that is purely combinational.

Verification
REQ-036 Sequential fetch, pc_in=0, imem_ready=1 on the first WAIT cycle: imem_addr=0, then fetch_valid=1 with fetch_pc=0, and PC advances once per 2 cycles.
REQ-037 Simultaneous exc_req (0x40), irq_req (0x80) and br_req (0x100) in IDLE: target=0x40, exc_ack only, flush=1; the next cycle gives target=0x80 with irq_ack.
REQ-038 br_req with br_target=0x103 in WAIT, then ready after 3 cycles: data discarded, no PC advance, then redirect to 0x100 in IDLE with br_ack.
REQ-039 pipe_stall=1 with a full buffer: no new imem_req and the buffer stays stable; pipe_stall=0 consumes it and the next request issues in the same cycle.
REQ-040 imem_ready stuck at 0 with WAIT_TIMEOUT=16: fetch_err pulses after 16 WAIT cycles, PC is unchanged, and the same imem_addr is reissued.
REQ-041 rst asserted mid-WAIT, then imem_ready=1: all outputs take their reset values and the buffer stays empty.
